// File: rtl/motor_duty_ramp_pkg.sv
// Shared types and widths for the motor duty slew limiter / command watchdog.
package motor_duty_ramp_pkg;

    localparam int PERIOD_LENGTH = 16;

    typedef enum logic [1:0] {
        MDR_IDLE = 2'd0,
        MDR_RUN  = 2'd1,
        MDR_TRIP = 2'd2
    } mdr_state_e;

endpackage

// File: rtl/motor_duty_ramp_slew_channel.sv
// One motor channel: live duty and target registers with a saturating
// per-tick step toward the target.
module duty_slew_channel #(
    parameter int DUTY_W = 16,
    parameter int STEP   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              clr_duty,
    input  logic              clr_tgt,
    input  logic              wr_en,
    input  logic [DUTY_W-1:0] wr_duty,
    output logic [DUTY_W-1:0] duty,
    output logic              at_target
);

    localparam logic [DUTY_W:0] STEP_W = (DUTY_W+1)'(STEP);

    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] tgt_q;
    logic [DUTY_W-1:0] duty_nxt;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W:0]   dn_diff;

    // One extra bit so overshoot past full scale or below zero is visible.
    assign up_sum  = {1'b0, duty_q} + STEP_W;
    assign dn_diff = {1'b0, duty_q} - STEP_W;

    always_comb begin
        duty_nxt = duty_q;
        if (duty_q < tgt_q) begin
            if (up_sum > {1'b0, tgt_q})
                duty_nxt = tgt_q;
            else
                duty_nxt = up_sum[DUTY_W-1:0];
        end else if (duty_q > tgt_q) begin
            if (dn_diff[DUTY_W] || (dn_diff[DUTY_W-1:0] < tgt_q))
                duty_nxt = tgt_q;
            else
                duty_nxt = dn_diff[DUTY_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            duty_q <= '0;
        else if (clr_duty)
            duty_q <= '0;
        else if (tick)
            duty_q <= duty_nxt;
    end

    // A write landing on a tick cycle only affects the following tick.
    always_ff @(posedge clk) begin
        if (!reset)
            tgt_q <= '0;
        else if (clr_tgt)
            tgt_q <= '0;
        else if (wr_en)
            tgt_q <= wr_duty;
    end

    assign duty      = duty_q;
    assign at_target = (duty_q == tgt_q);

endmodule

// File: rtl/motor_duty_ramp.sv
// Slew-rate limiter and command watchdog in front of the motor duty inputs.
// state | meaning
// IDLE  | no command since reset/trip, targets at 0
// RUN   | commands flowing, watchdog counting ticks
// TRIP  | timeout or estop, targets forced to 0, duties ramping down
module motor_duty_ramp
    import motor_duty_ramp_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int DUTY_W       = PERIOD_LENGTH,
    parameter int STEP         = 16,
    parameter int TICK_DIV     = 5000,
    parameter int WDOG_TIMEOUT = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [2:0]               cmd_ch,
    input  logic [DUTY_W-1:0]        cmd_duty,
    output logic                     cmd_ready,
    input  logic                     estop,
    output logic [NUM_CH*DUTY_W-1:0] duty_out,
    output logic [NUM_CH-1:0]        at_target,
    output logic                     tripped
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WW = (WDOG_TIMEOUT > 1) ? $clog2(WDOG_TIMEOUT + 1) : 1;

    mdr_state_e    state_q, state_d;
    logic [PW-1:0] presc_q;
    logic [WW-1:0] wdog_q;
    logic          tick;
    logic          accept;
    logic          in_range;
    logic          kick;
    logic          timeout;
    logic          all_zero;
    logic          clr_tgt;

    assign tick      = (presc_q == PW'(TICK_DIV - 1));
    assign cmd_ready = (state_q != MDR_TRIP) && !estop;
    assign tripped   = (state_q == MDR_TRIP);
    assign accept    = cmd_valid && cmd_ready;
    assign in_range  = (int'(cmd_ch) < NUM_CH);
    assign kick      = accept && in_range;
    assign timeout   = (state_q == MDR_RUN) && tick && (wdog_q == WW'(WDOG_TIMEOUT - 1));
    assign all_zero  = ~|duty_out;

    always_ff @(posedge clk) begin
        if (!reset)
            presc_q <= '0;
        else if (tick)
            presc_q <= '0;
        else
            presc_q <= presc_q + 1'b1;
    end

    // Held at zero outside RUN so entry into RUN always starts a fresh count.
    always_ff @(posedge clk) begin
        if (!reset)
            wdog_q <= '0;
        else if ((state_q != MDR_RUN) || estop || kick)
            wdog_q <= '0;
        else if (tick)
            wdog_q <= wdog_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= MDR_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (estop) begin
            state_d = MDR_TRIP;
        end else begin
            case (state_q)
                MDR_IDLE: if (kick) state_d = MDR_RUN;
                MDR_RUN:  if (timeout && !kick) state_d = MDR_TRIP;
                MDR_TRIP: if (all_zero) state_d = MDR_IDLE;
                default:  state_d = MDR_IDLE;
            endcase
        end
    end

    assign clr_tgt = estop || (state_q == MDR_TRIP) || (state_d == MDR_TRIP);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        duty_slew_channel #(
            .DUTY_W (DUTY_W),
            .STEP   (STEP)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .clr_duty  (estop),
            .clr_tgt   (clr_tgt),
            .wr_en     (accept && (cmd_ch == 3'(i))),
            .wr_duty   (cmd_duty),
            .duty      (duty_out[i*DUTY_W +: DUTY_W]),
            .at_target (at_target[i])
        );
    end

endmodule

// File: tb/tb_motor_duty_ramp.sv
// Directed bench for motor_duty_ramp: ramping, same-cycle write, watchdog,
// estop, saturation and out-of-range channel handling.
module tb_motor_duty_ramp;

    localparam int DW = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           cmd_valid, estop;
    logic [2:0]     cmd_ch;
    logic [DW-1:0]  cmd_duty;
    logic           cmd_ready, tripped;
    logic [8*DW-1:0] duty_out;
    logic [7:0]     at_target;

    logic           cmd_valid_b, estop_b;
    logic [2:0]     cmd_ch_b;
    logic [DW-1:0]  cmd_duty_b;
    logic           cmd_ready_b, tripped_b;
    logic [6*DW-1:0] duty_out_b;
    logic [5:0]     at_target_b;

    int n_pass  = 0;
    int n_total = 0;
    int pc;

    motor_duty_ramp #(.NUM_CH(8), .DUTY_W(DW), .STEP(10), .TICK_DIV(4), .WDOG_TIMEOUT(20)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_duty(cmd_duty),
        .cmd_ready(cmd_ready), .estop(estop), .duty_out(duty_out), .at_target(at_target),
        .tripped(tripped)
    );

    motor_duty_ramp #(.NUM_CH(6), .DUTY_W(DW), .STEP(10), .TICK_DIV(4), .WDOG_TIMEOUT(20)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ch(cmd_ch_b), .cmd_duty(cmd_duty_b),
        .cmd_ready(cmd_ready_b), .estop(estop_b), .duty_out(duty_out_b), .at_target(at_target_b),
        .tripped(tripped_b)
    );

    always #5 clk = ~clk;

    // Tick phase reference: a tick edge follows every cycle where pc == 3.
    always @(posedge clk) begin
        if (!reset) pc <= 0;
        else        pc <= (pc == 3) ? 0 : pc + 1;
    end

    function automatic logic [DW-1:0] ch(input int i);
        return duty_out[i*DW +: DW];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_tick();
        for (int n = 0; n < 8 && pc != 3; n++) step();
    endtask

    task automatic next_tick();
        sync_tick();
        step();
    endtask

    task automatic cmd(input logic [2:0] c, input logic [DW-1:0] d);
        cmd_valid = 1'b1; cmd_ch = c; cmd_duty = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic cmd_b(input logic [2:0] c, input logic [DW-1:0] d);
        cmd_valid_b = 1'b1; cmd_ch_b = c; cmd_duty_b = d;
        step();
        cmd_valid_b = 1'b0;
    endtask

    initial begin
        reset = 1'b0; estop = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_duty = '0;
        estop_b = 1'b0; cmd_valid_b = 1'b0; cmd_ch_b = '0; cmd_duty_b = '0;
        repeat (3) step();
        chk("rst_duty", duty_out, '0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_tripped", tripped, 1'b0);
        chk("rst_at_target", at_target, 8'hFF);
        chk("rst_b_at_target", at_target_b, 6'h3F);
        reset = 1'b1;
        step();

        // up-ramp on channel 2
        cmd(3'd2, 16'd35);
        chk("up_at_target_pending", at_target[2], 1'b0);
        next_tick(); chk("up_t1", ch(2), 16'd10);
        next_tick(); chk("up_t2", ch(2), 16'd20);
        next_tick(); chk("up_t3", ch(2), 16'd30);
        next_tick(); chk("up_t4", ch(2), 16'd35);
        chk("up_at_target", at_target[2], 1'b1);
        chk("up_others_zero", duty_out & ~(128'hFFFF << 32), '0);
        chk("up_run_ready", cmd_ready, 1'b1);

        // down-ramp, then a write that lands on the tick edge
        cmd(3'd2, 16'd0);
        next_tick(); chk("dn_t1", ch(2), 16'd25);
        next_tick(); chk("dn_t2", ch(2), 16'd15);
        next_tick(); chk("dn_t3", ch(2), 16'd5);
        sync_tick();
        cmd(3'd2, 16'd100);
        chk("same_cycle_old_target", ch(2), 16'd0);
        next_tick(); chk("same_cycle_new_target", ch(2), 16'd10);

        // watchdog trip after 20 silent ticks
        cmd(3'd2, 16'd0);
        cmd(3'd0, 16'd50);
        for (int k = 1; k <= 19; k++) begin
            next_tick();
            if (k == 5) chk("wd_ch0_reach", ch(0), 16'd50);
        end
        chk("wd_not_yet", tripped, 1'b0);
        next_tick();
        chk("wd_tripped", tripped, 1'b1);
        chk("wd_ready_low", cmd_ready, 1'b0);
        chk("wd_ch0_at_trip", ch(0), 16'd50);
        for (int k = 1; k <= 5; k++) begin
            next_tick();
            chk($sformatf("wd_rampdown_%0d", k), ch(0), 16'(50 - 10 * k));
        end
        chk("wd_still_trip_at_zero", tripped, 1'b1);
        step();
        chk("wd_idle", tripped, 1'b0);
        chk("wd_idle_ready", cmd_ready, 1'b1);
        chk("wd_idle_at_target", at_target, 8'hFF);

        // command on the exact timeout cycle keeps RUN and restarts the count
        cmd(3'd0, 16'd50);
        repeat (19) next_tick();
        sync_tick();
        cmd(3'd3, 16'd0);
        chk("wd_cmd_wins", tripped, 1'b0);
        chk("wd_cmd_wins_ready", cmd_ready, 1'b1);
        repeat (19) next_tick();
        chk("wd_restart_not_yet", tripped, 1'b0);
        next_tick();
        chk("wd_restart_trip", tripped, 1'b1);
        repeat (5) next_tick();
        step();
        chk("wd_restart_idle", tripped, 1'b0);

        // estop during an up-ramp
        cmd(3'd1, 16'd100);
        repeat (3) next_tick();
        chk("es_ch1_before", ch(1), 16'd30);
        estop = 1'b1;
        step();
        chk("es_duty_zero", duty_out, '0);
        chk("es_tripped", tripped, 1'b1);
        chk("es_ready_low", cmd_ready, 1'b0);
        chk("es_at_target", at_target, 8'hFF);
        cmd_valid = 1'b1; cmd_ch = 3'd1; cmd_duty = 16'd77;
        repeat (6) step();
        cmd_valid = 1'b0;
        chk("es_hold_tripped", tripped, 1'b1);
        chk("es_hold_duty", duty_out, '0);
        estop = 1'b0;
        chk("es_release_ready_trip", cmd_ready, 1'b0);
        step();
        chk("es_idle", tripped, 1'b0);
        chk("es_idle_ready", cmd_ready, 1'b1);
        chk("es_idle_duty", duty_out, '0);

        // saturation at full scale
        cmd(3'd5, 16'hFFFF);
        for (int k = 1; k <= 6553; k++) begin
            next_tick();
            if (k % 10 == 0) cmd(3'd5, 16'hFFFF);
        end
        chk("sat_fffa", ch(5), 16'hFFFA);
        chk("sat_not_at_target", at_target[5], 1'b0);
        next_tick(); chk("sat_ffff", ch(5), 16'hFFFF);
        next_tick(); chk("sat_hold", ch(5), 16'hFFFF);
        chk("sat_at_target", at_target[5], 1'b1);
        chk("sat_no_trip", tripped, 1'b0);

        // out-of-range channel on the 6-channel instance does not feed the watchdog
        cmd_b(3'd0, 16'd20);
        repeat (15) next_tick();
        chk("oor_ready", cmd_ready_b, 1'b1);
        cmd_b(3'd7, 16'd123);
        chk("oor_no_effect", at_target_b, 6'h3F);
        repeat (4) next_tick();
        chk("oor_not_yet", tripped_b, 1'b0);
        chk("oor_ch0", duty_out_b[DW-1:0], 16'd20);
        next_tick();
        chk("oor_trip", tripped_b, 1'b1);
        chk("oor_trip_at_target", at_target_b, 6'h3E);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/motor_duty_ramp.md
Name: motor_duty_ramp

Overview:
- Slew-rate limiter and command watchdog placed between the Avalon register writes and the eight motor_controller duty inputs.
- Software writes target duties. The block steps each channel's live duty toward its target by a fixed amount per ramp tick.
- If commands stop arriving, or estop is raised, it trips and forces all duties to zero, protecting thrusters from step loads and a hung host.

Parameters:
- NUM_CH, 8: number of motor channels (1..8).
- DUTY_W, `PERIOD_LENGTH (16): duty word width, taken from defines.v.
- STEP, 16: maximum duty change per ramp tick.
- TICK_DIV, 5000: clock cycles per ramp tick (>=2).
- WDOG_TIMEOUT, 1000: ramp ticks without an accepted command before tripping (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous and active-low.
- cmd_valid  in  1  target-duty write request.
- cmd_ch  in  3  channel index for the write.
- cmd_duty  in  DUTY_W  requested target duty.
- cmd_ready  out  1  block can accept a command.
- estop  in  1  emergency stop, level-sensitive.
- duty_out  out  NUM_CH*DUTY_W  live duties; channel i occupies bits [(i+1)*DUTY_W-1 : i*DUTY_W].
- at_target  out  NUM_CH  channel i duty equals its target.
- tripped  out  1  high while in TRIP.

Behaviour:
- Reset (reset==0 at a clk edge):
  - duty_out, all targets, prescaler and watchdog counter go to 0.
  - state=IDLE, cmd_ready=1, tripped=0, at_target all 1.
- Handshake:
  - A command is accepted on a cycle with cmd_valid & cmd_ready.
  - target[cmd_ch] <= cmd_duty on that edge.
  - cmd_ch >= NUM_CH: accepted, discarded, and does not kick the watchdog.
  - cmd_ready = (state != TRIP) & ~estop, derived combinationally from the registered state.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is asserted for one cycle when count==TICK_DIV-1.
  - Free-runs in every state.
- Ramp, on tick, every channel in parallel:
  - if duty<target: duty <= min(duty+STEP, target).
  - if duty>target: duty <= max(duty-STEP, target).
  - Arithmetic is done in DUTY_W+1 bits. Results never wrap past 0 or 2^DUTY_W-1.
  - If a command and a tick hit the same channel in the same cycle, the ramp uses the old target; the new target takes effect from the next tick.
- Latency:
  - Command to first duty change: up to TICK_DIV cycles.
  - duty_out is registered.
- Watchdog:
  - Counts ticks in RUN only.
  - Cleared to 0 by any accepted in-range command, and on entry to RUN.
- State machine:
  - IDLE: targets idle at 0. An accepted in-range command goes to RUN.
  - RUN: when the watchdog reaches WDOG_TIMEOUT, go to TRIP.
    - If an accepted command and the timeout occur in the same cycle, the command wins: counter cleared, remain RUN.
  - TRIP: all targets are cleared to 0 on entry and held at 0. Duties ramp down at STEP per tick.
    - Leave to IDLE on the cycle after all duties are 0 and estop is low.
  - estop high in any state: next edge sets all duties and targets to 0 and goes to TRIP.
    - The block remains in TRIP while estop is high.
    - estop overrides the handshake and the ramp in the same cycle.
- at_target[i] = (duty[i]==target[i]), combinational from registers.
- Reset asserted mid-ramp or mid-TRIP returns to the reset values on the next edge, with no ramp-down.

Decomposition:
- Use the existing `PERIOD_LENGTH from defines.v.
- Add to defines.v: state encoding macros MDR_IDLE=2'd0, MDR_RUN=2'd1, MDR_TRIP=2'd2.
- One sub-module, duty_slew_channel: holds one channel's duty and target registers, the saturating step logic and at_target. It is instantiated NUM_CH times in a generate loop.
- The top level holds the prescaler, watchdog, FSM and command decode.

Test Plan (bench parameters: TICK_DIV=4, STEP=10, WDOG_TIMEOUT=20):
- Reset: hold reset=0 for 3 cycles -> duty_out=0, cmd_ready=1, tripped=0, at_target=8'hFF.
- Up-ramp: accept ch2=35 -> ch2 duty goes 10, 20, 30, 35 on successive ticks (4 cycles apart), then at_target[2]=1; the other channels stay 0.
- Down-ramp and same-cycle edge: from 35 write ch2=0 -> 25, 15, 5, 0. A write of ch2=100 on a tick cycle -> that tick still uses the old target.
- Watchdog: command ch0=50, then no commands -> after 20 ticks tripped=1 and cmd_ready=0; ch0 goes 40..0; one cycle later state IDLE and cmd_ready=1. A command accepted on the exact timeout cycle -> no trip.
- estop: during an up-ramp (ch1 at 30), raise estop -> next edge all duty_out=0 and tripped=1; hold while estop=1; lower estop -> IDLE one cycle later.
- Saturation and ignored channel: target ch5=16'hFFFF from 0 with STEP=10 -> ramp reaches 16'hFFFA, then 16'hFFFF, with no wrap. A command with cmd_ch=7 while NUM_CH=6 is accepted and ignored, and does not clear the watchdog.
